// File: rtl/mem_responder.sv
// Latency-modelled single-port word memory shared by an instruction and a data port.
// Round-robin arbitration, one access in flight, sticky protocol-error flag.
module mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_mem_address,
    input  logic        inst_mem_read,
    output logic [31:0] inst_mem_rdata,
    output logic        inst_mem_resp,
    input  logic [31:0] data_mem_address,
    input  logic        data_mem_read,
    input  logic        data_mem_write,
    input  logic [3:0]  data_mem_byte_enable,
    input  logic [31:0] data_mem_wdata,
    output logic [31:0] data_mem_rdata,
    output logic        data_mem_resp,
    output logic        err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
    localparam logic GNT_INST = 1'b0;
    localparam logic GNT_DATA = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        inst_resp_q, inst_resp_d;
    logic        data_resp_q, data_resp_d;
    logic        err_q, err_d;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           mem_rd;
    logic [31:0]           mem_wr_word;
    logic                  mem_we;
    logic                  pend_i, pend_d, pick;

    assign idx    = addr_q[DEPTH_LOG2+1:2];
    assign mem_rd = mem[idx];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mem_wr_word[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : mem_rd[8*i +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        last_d      = last_q;
        is_wr_d     = is_wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rdata_d     = '0;
        inst_resp_d = 1'b0;
        data_resp_d = 1'b0;
        err_d       = err_q;
        mem_we      = 1'b0;
        pend_i      = inst_mem_read;
        pend_d      = data_mem_read | data_mem_write;
        pick        = pend_d && (!pend_i || last_q == GNT_INST);

        case (state_q)
            S_IDLE: begin
                if (pend_i || pend_d) begin
                    grant_d = pick;
                    last_d  = pick;
                    addr_d  = pick ? data_mem_address : inst_mem_address;
                    wdata_d = data_mem_wdata;
                    be_d    = data_mem_byte_enable;
                    is_wr_d = pick && data_mem_write;
                    if (pick && data_mem_read && data_mem_write) begin
                        err_d = 1'b1;
                    end
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // the granted master must hold its request steady until resp
                if (grant_q == GNT_DATA) begin
                    if (!pend_d || data_mem_address != addr_q) err_d = 1'b1;
                end else begin
                    if (!pend_i || inst_mem_address != addr_q) err_d = 1'b1;
                end
                if (cnt_q == 4'd0) begin
                    mem_we      = is_wr_q;
                    rdata_d     = is_wr_q ? 32'h0 : mem_rd;
                    inst_resp_d = (grant_q == GNT_INST);
                    data_resp_d = (grant_q == GNT_DATA);
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            grant_q     <= GNT_INST;
            last_q      <= GNT_INST;
            is_wr_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rdata_q     <= '0;
            inst_resp_q <= 1'b0;
            data_resp_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            is_wr_q     <= is_wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rdata_q     <= rdata_d;
            inst_resp_q <= inst_resp_d;
            data_resp_q <= data_resp_d;
            err_q       <= err_d;
        end
    end

    // array is intentionally not reset; a reset landing on the commit edge drops the write
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[idx] <= mem_wr_word;
        end
    end

    assign inst_mem_resp  = inst_resp_q & ~rst;
    assign data_mem_resp  = data_resp_q & ~rst;
    assign inst_mem_rdata = (inst_resp_q && !rst) ? rdata_q : 32'h0;
    assign data_mem_rdata = (data_resp_q && !rst) ? rdata_q : 32'h0;
    assign err            = err_q & ~rst;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus pushes expected responses,
// an independent monitor pops and checks port, data and arrival cycle.
module tb_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_mem_address;
    logic        inst_mem_read;
    logic [31:0] inst_mem_rdata;
    logic        inst_mem_resp;
    logic [31:0] data_mem_address;
    logic        data_mem_read;
    logic        data_mem_write;
    logic [3:0]  data_mem_byte_enable;
    logic [31:0] data_mem_wdata;
    logic [31:0] data_mem_rdata;
    logic        data_mem_resp;
    logic        err;

    mem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT)) dut (
        .clk(clk),
        .rst(rst),
        .inst_mem_address(inst_mem_address),
        .inst_mem_read(inst_mem_read),
        .inst_mem_rdata(inst_mem_rdata),
        .inst_mem_resp(inst_mem_resp),
        .data_mem_address(data_mem_address),
        .data_mem_read(data_mem_read),
        .data_mem_write(data_mem_write),
        .data_mem_byte_enable(data_mem_byte_enable),
        .data_mem_wdata(data_mem_wdata),
        .data_mem_rdata(data_mem_rdata),
        .data_mem_resp(data_mem_resp),
        .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          port;   // 1 = data, 0 = inst
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // monitor: compares every response against the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (inst_mem_resp || data_mem_resp) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_resp: inst_resp=%0b data_resp=%0b at cycle %0d",
                             inst_mem_resp, data_mem_resp, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.port) begin
                        if (data_mem_resp && !inst_mem_resp && data_mem_rdata === e.rdata &&
                            inst_mem_rdata === 32'h0 && cyc == e.cyc)
                            n_pass++;
                        else
                            $display("FAIL data_resp: resp d/i=%0b/%0b rdata=%h other=%h cyc=%0d expected rdata=%h cyc=%0d",
                                     data_mem_resp, inst_mem_resp, data_mem_rdata, inst_mem_rdata,
                                     cyc, e.rdata, e.cyc);
                    end else begin
                        if (inst_mem_resp && !data_mem_resp && inst_mem_rdata === e.rdata &&
                            data_mem_rdata === 32'h0 && cyc == e.cyc)
                            n_pass++;
                        else
                            $display("FAIL inst_resp: resp i/d=%0b/%0b rdata=%h other=%h cyc=%0d expected rdata=%h cyc=%0d",
                                     inst_mem_resp, data_mem_resp, inst_mem_rdata, data_mem_rdata,
                                     cyc, e.rdata, e.cyc);
                    end
                end
            end else if (inst_mem_rdata !== 32'h0 || data_mem_rdata !== 32'h0) begin
                n_total++;
                $display("FAIL idle_rdata: inst=%h data=%h expected 0 at cycle %0d",
                         inst_mem_rdata, data_mem_rdata, cyc);
            end
        end
    end

    task automatic push(input bit port, input logic [31:0] rdata, input int delay);
        exp_t e;
        e.port  = port;
        e.rdata = rdata;
        e.cyc   = cyc + delay;
        exp_q.push_back(e);
    endtask

    task automatic wait_resp(input bit port);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(port ? data_mem_resp : inst_mem_resp) && n < 40);
        if (n >= 40) begin
            n_total++;
            $display("FAIL timeout: port=%0d got no resp, expected one within 40 cycles", port);
        end
    endtask

    task automatic drop_inst();
        inst_mem_read    = 1'b0;
        inst_mem_address = 32'h0;
    endtask

    task automatic drop_data();
        data_mem_read        = 1'b0;
        data_mem_write       = 1'b0;
        data_mem_address     = 32'h0;
        data_mem_wdata       = 32'h0;
        data_mem_byte_enable = 4'h0;
    endtask

    task automatic set_data(input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be);
        data_mem_read        = rd;
        data_mem_write       = wr;
        data_mem_address     = a;
        data_mem_wdata       = wd;
        data_mem_byte_enable = be;
    endtask

    task automatic data_acc(input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be, input logic [31:0] exp);
        @(negedge clk);
        push(1'b1, exp, LAT + 1);
        set_data(rd, wr, a, wd, be);
        wait_resp(1'b1);
        drop_data();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_inst_resp", {31'h0, inst_mem_resp}, 32'h0);
        check("rst_data_resp", {31'h0, data_mem_resp}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_rdata", inst_mem_rdata | data_mem_rdata, 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drop_inst();
        drop_data();
        do_reset();

        // full write, read back, byte lanes
        data_acc(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0);
        data_acc(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF);
        data_acc(1'b0, 1'b1, 32'h100, 32'h000000AA, 4'h1, 32'h0);
        data_acc(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEAA);
        data_acc(1'b0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'h0, 32'h0);
        data_acc(1'b1, 1'b0, 32'h100, 32'h0, 4'hA, 32'hDEADBEAA);
        data_acc(1'b0, 1'b1, 32'h104, 32'hCAFEF00D, 4'hF, 32'h0);
        check("err_clean", {31'h0, err}, 32'h0);

        // simultaneous requests from reset: data first, inst one slot later
        do_reset();
        @(negedge clk);
        push(1'b1, 32'hCAFEF00D, LAT + 1);
        push(1'b0, 32'hDEADBEAA, 2 * (LAT + 2) - 1);
        inst_mem_read    = 1'b1;
        inst_mem_address = 32'h100;
        set_data(1'b1, 1'b0, 32'h104, 32'h0, 4'h0);
        wait_resp(1'b1);
        drop_data();
        wait_resp(1'b0);
        drop_inst();

        // wrap-around through ignored upper index bits
        data_acc(1'b0, 1'b1, 32'h1000, 32'h12345678, 4'hF, 32'h0);
        data_acc(1'b1, 1'b0, 32'h0000, 32'h0, 4'h0, 32'h12345678);

        // last grant was data, so inst wins the tie
        @(negedge clk);
        push(1'b0, 32'h12345678, LAT + 1);
        push(1'b1, 32'hDEADBEAA, 2 * (LAT + 2) - 1);
        inst_mem_read    = 1'b1;
        inst_mem_address = 32'h2000_0003;
        set_data(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        wait_resp(1'b0);
        drop_inst();
        wait_resp(1'b1);
        drop_data();
        check("err_after_rr", {31'h0, err}, 32'h0);

        // reset on the commit edge aborts the write
        data_acc(1'b0, 1'b1, 32'h200, 32'h11111111, 4'hF, 32'h0);
        @(negedge clk);
        set_data(1'b0, 1'b1, 32'h200, 32'h22222222, 4'hF);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        drop_data();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_queue_empty", exp_q.size(), 32'h0);
        data_acc(1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 32'h11111111);

        // read+write together: performed as a write, err sticks until reset
        data_acc(1'b1, 1'b1, 32'h300, 32'h5A5A5A5A, 4'hF, 32'h0);
        check("err_rw_set", {31'h0, err}, 32'h1);
        data_acc(1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 32'h5A5A5A5A);
        check("err_sticky", {31'h0, err}, 32'h1);
        do_reset();
        check("err_cleared", {31'h0, err}, 32'h0);

        // address change during WAIT flags err but still completes on the latched address
        @(negedge clk);
        push(1'b1, 32'hDEADBEAA, LAT + 1);
        set_data(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        @(negedge clk);
        data_mem_address = 32'h104;
        wait_resp(1'b1);
        drop_data();
        check("err_addr_change", {31'h0, err}, 32'h1);
        do_reset();

        repeat (4) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
